// File: rtl/plru_state_array.sv
// plru_state_array: per-set tree pseudo-LRU state store for an N-way cache.
// Holds WAYS-1 heap-indexed tree bits per set. The victim way is derived
// combinationally from the captured lookup, with invalid ways preferred.
// Hits/fills apply the tree touch. A multi-cycle sweep clears every set.
module plru_state_array #(
   parameter  int S_INDEX  = 4,
   parameter  int WAYS     = 4,
   localparam int NUM_SETS = 2**S_INDEX,
   localparam int W_IDX    = $clog2(WAYS)
) (
   input  logic               clk0,
   input  logic               rst0_n,
   input  logic               rd_en,
   input  logic [S_INDEX-1:0] rd_set,
   input  logic [WAYS-1:0]    rd_valid,
   output logic               rd_resp,
   output logic [W_IDX-1:0]   rd_victim,
   output logic [WAYS-2:0]    rd_state,
   input  logic               upd_en,
   input  logic [S_INDEX-1:0] upd_set,
   input  logic [W_IDX-1:0]   upd_way,
   input  logic               flush_req,
   output logic               busy
);

   typedef enum logic {IDLE, FLUSH} fsm_t;

   fsm_t               state;
   fsm_t               state_next;
   logic [S_INDEX-1:0] counter;
   logic [WAYS-2:0]    plru_mem [NUM_SETS];
   logic [S_INDEX-1:0] rd_set_reg;
   logic [WAYS-1:0]    rd_valid_reg;
   logic               accept;

   // Point every node on the path of 'way' away from it; off-path nodes keep their bits.
   function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] st,
                                              input logic [W_IDX-1:0] way);
      logic [WAYS-2:0] res;
      int              node;
      res  = st;
      node = 0;
      for (int lvl = 0; lvl < W_IDX; lvl++) begin
         if (way[W_IDX-1-lvl]) begin
            res[node] = 1'b0;
            node      = 2*node + 2;
         end else begin
            res[node] = 1'b1;
            node      = 2*node + 1;
         end
      end
      return res;
   endfunction

   // Follow the tree bits from the root: 0 = lower half, 1 = upper half.
   function automatic logic [W_IDX-1:0] tree_victim(input logic [WAYS-2:0] st);
      logic [W_IDX-1:0] way;
      int               node;
      way  = '0;
      node = 0;
      for (int lvl = 0; lvl < W_IDX; lvl++) begin
         way[W_IDX-1-lvl] = st[node];
         if (st[node]) node = 2*node + 2;
         else          node = 2*node + 1;
      end
      return way;
   endfunction

   // Lowest-index way whose valid bit is clear (only meaningful when one exists).
   function automatic logic [W_IDX-1:0] first_invalid(input logic [WAYS-1:0] v);
      logic [W_IDX-1:0] way;
      way = '0;
      for (int i = WAYS-1; i >= 0; i--) begin
         if (!v[i]) way = W_IDX'(i);
      end
      return way;
   endfunction

   // Requests are dropped while sweeping and in the cycle a sweep is accepted.
   assign accept = (state == IDLE) && !flush_req;
   assign busy   = (state == FLUSH);

   // FSM state register.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) state <= IDLE;
      else         state <= state_next;
   end

   // FSM next state: IDLE -> FLUSH on flush_req, back after the last set is cleared.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (flush_req) state_next = FLUSH;
         FLUSH:   if (counter == S_INDEX'(NUM_SETS-1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Sweep pointer: held at zero in IDLE so each sweep starts at set 0.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n)            counter <= '0;
      else if (state == IDLE) counter <= '0;
      else                    counter <= counter + 1'b1;
   end

   // State array: sweep clears one set per cycle, otherwise accepted touches update.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         for (int i = 0; i < NUM_SETS; i++) plru_mem[i] <= '0;
      end else if (state == FLUSH) begin
         plru_mem[counter] <= '0;
      end else if (accept && upd_en) begin
         plru_mem[upd_set] <= touch(plru_mem[upd_set], upd_way);
      end
   end

   // Lookup capture; outputs then read the live array so same-edge writes are seen.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         rd_resp      <= 1'b0;
         rd_set_reg   <= '0;
         rd_valid_reg <= '1;
      end else begin
         rd_resp <= accept && rd_en;
         if (accept && rd_en) begin
            rd_set_reg   <= rd_set;
            rd_valid_reg <= rd_valid;
         end
      end
   end

   // Victim selection: invalid ways win over the tree walk.
   always_comb begin
      rd_state  = plru_mem[rd_set_reg];
      rd_victim = tree_victim(rd_state);
      if (rd_valid_reg != '1) rd_victim = first_invalid(rd_valid_reg);
   end

endmodule

// File: tb/tb_plru_state_array.sv
// tb_plru_state_array: scoreboard bench for plru_state_array (S_INDEX=4, WAYS=4).
module tb_plru_state_array;

   localparam int S_INDEX  = 4;
   localparam int WAYS     = 4;
   localparam int NUM_SETS = 2**S_INDEX;
   localparam int W_IDX    = 2;

   typedef struct {
      logic [W_IDX-1:0] victim;
      logic [WAYS-2:0]  st;
   } exp_t;

   logic               clk0 = 1'b0;
   logic               rst0_n = 1'b0;
   logic               rd_en = 1'b0;
   logic [S_INDEX-1:0] rd_set = '0;
   logic [WAYS-1:0]    rd_valid = '1;
   logic               rd_resp;
   logic [W_IDX-1:0]   rd_victim;
   logic [WAYS-2:0]    rd_state;
   logic               upd_en = 1'b0;
   logic [S_INDEX-1:0] upd_set = '0;
   logic [W_IDX-1:0]   upd_way = '0;
   logic               flush_req = 1'b0;
   logic               busy;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb_q[$];
   logic [WAYS-2:0] model [NUM_SETS];
   int   busy_left = 0;
   int   busy_seen = 0;

   plru_state_array #(.S_INDEX(S_INDEX), .WAYS(WAYS)) dut (
      .clk0(clk0), .rst0_n(rst0_n),
      .rd_en(rd_en), .rd_set(rd_set), .rd_valid(rd_valid),
      .rd_resp(rd_resp), .rd_victim(rd_victim), .rd_state(rd_state),
      .upd_en(upd_en), .upd_set(upd_set), .upd_way(upd_way),
      .flush_req(flush_req), .busy(busy)
   );

   always #5 clk0 = ~clk0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   // Reference touch: narrow a [lo, lo+size) way range down the tree.
   function automatic logic [WAYS-2:0] ref_touch(input logic [WAYS-2:0] st, input int way);
      int lo = 0, size = WAYS, node = 0, half;
      while (size > 1) begin
         half = size / 2;
         if (way < lo + half) begin st[node] = 1'b1; node = 2*node + 1; end
         else begin st[node] = 1'b0; lo += half; node = 2*node + 2; end
         size = half;
      end
      return st;
   endfunction

   function automatic logic [W_IDX-1:0] ref_victim(input logic [WAYS-2:0] st, input logic [WAYS-1:0] v);
      int lo = 0, size = WAYS, node = 0, half;
      for (int i = 0; i < WAYS; i++) if (!v[i]) return W_IDX'(i);
      while (size > 1) begin
         half = size / 2;
         if (st[node]) begin lo += half; node = 2*node + 2; end
         else node = 2*node + 1;
         size = half;
      end
      return W_IDX'(lo);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NUM_SETS; i++) model[i] = '0;
   endtask

   // One cycle: check outputs of the previous edge, then drive and model the next one.
   task automatic step(input logic re, input int rs, input logic [WAYS-1:0] rv,
                       input logic ue, input int us, input int uw, input logic fr);
      exp_t e;
      logic acc;
      @(negedge clk0);
      check_val("busy", busy, busy_left > 0);
      if (busy) busy_seen++;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val("rd_resp", rd_resp, 1);
         check_val("rd_victim", rd_victim, e.victim);
         check_val("rd_state", rd_state, e.st);
      end else begin
         check_val("rd_resp_idle", rd_resp, 0);
      end
      rd_en = re; rd_set = S_INDEX'(rs); rd_valid = rv;
      upd_en = ue; upd_set = S_INDEX'(us); upd_way = W_IDX'(uw);
      flush_req = fr;
      acc = (busy_left == 0) && !fr;
      if (busy_left > 0) busy_left--;
      else if (fr) begin busy_left = NUM_SETS; model_clear(); end
      if (acc && ue) model[us] = ref_touch(model[us], uw);
      if (acc && re) begin
         e.st = model[rs];
         e.victim = ref_victim(model[rs], rv);
         sb_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '1, 0, 0, 0, 0);
   endtask

   task automatic lookup(input int s, input logic [WAYS-1:0] v);
      step(1, s, v, 0, 0, 0, 0);
   endtask

   task automatic touch(input int s, input int w);
      step(0, 0, '1, 1, s, w, 0);
   endtask

   initial begin
      model_clear();
      #2;
      check_val("rst_busy", busy, 0);
      check_val("rst_resp", rd_resp, 0);
      check_val("rst_victim", rd_victim, 0);
      check_val("rst_state", rd_state, 0);
      @(negedge clk0); @(negedge clk0);
      rst0_n = 1'b1;

      // Directed lookups from the test plan.
      lookup(3, 4'b1111);
      touch(3, 0);
      lookup(3, 4'b1111);
      idle(1);
      check_val("plan_state_011", rd_state, 3'b011);
      check_val("plan_victim_2", rd_victim, 2);
      touch(3, 2);
      lookup(3, 4'b1111);
      idle(1);
      check_val("plan_state_110", rd_state, 3'b110);
      check_val("plan_victim_1", rd_victim, 1);
      step(1, 5, 4'b1111, 1, 5, 0, 0);
      idle(1);
      check_val("wf_state", rd_state, 3'b011);
      check_val("wf_victim", rd_victim, 2);
      lookup(3, 4'b1011);
      idle(1);
      check_val("inv_victim", rd_victim, 2);
      lookup(3, 4'b0110);
      lookup(3, 4'b0111);
      for (int w = 0; w < WAYS; w++) touch(7, w);
      lookup(7, 4'b1111);

      // Flush with requests during busy; one late-sweep touch of set 0 must be dropped.
      for (int s = 0; s < NUM_SETS; s++) touch(s, s % WAYS);
      busy_seen = 0;
      step(0, 0, '1, 0, 0, 0, 1);
      for (int i = 0; i < NUM_SETS; i++) step(1, i, '1, 1, 0, i % WAYS, i == 3);
      idle(2);
      check_val("busy_cycles", busy_seen, NUM_SETS);
      for (int s = 0; s < NUM_SETS; s++) lookup(s, '1);
      idle(1);

      // Asynchronous reset in the middle of a sweep.
      for (int s = 8; s < NUM_SETS; s++) touch(s, 3);
      step(0, 0, '1, 0, 0, 0, 1);
      idle(3);
      @(posedge clk0);
      #2 rst0_n = 1'b0;
      #1;
      check_val("arst_busy", busy, 0);
      check_val("arst_resp", rd_resp, 0);
      model_clear();
      sb_q.delete();
      busy_left = 0;
      @(negedge clk0);
      #1 rst0_n = 1'b1;
      for (int s = 0; s < NUM_SETS; s++) lookup(s, '1);
      step(0, 0, '1, 0, 0, 0, 1);
      idle(NUM_SETS + 2);

      // Random mix of touches, lookups and occasional sweeps.
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 1), $urandom_range(0, NUM_SETS-1), WAYS'($urandom_range(0, 15)),
              $urandom_range(0, 1), $urandom_range(0, NUM_SETS-1), $urandom_range(0, WAYS-1),
              $urandom_range(0, 60) == 0);
      idle(NUM_SETS + 2);
      check_val("sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/plru_state_array.md
# plru_state_array

Per-set tree pseudo-LRU state store for the N-way cache datapath. It generalises the fixed 3-bit LRU array to any power-of-two associativity. It computes the victim way internally, preferring invalid ways, and applies the tree update on each hit or fill. It also provides a multi-cycle flush sweep that clears all replacement state without a global reset. It sits beside the tag/valid arrays and is driven by the cache controller FSM.

## Interface
- S_INDEX, 4, set-index width; NUM_SETS = 2**S_INDEX
- WAYS, 4, associativity; power of two, >= 2; W_IDX = log2(WAYS); state width WAYS-1
- clk0  in  1  single clock, all state on rising edge
- rst0_n  in  1  reset, asynchronous, active-low
- rd_en  in  1  lookup request, sampled on clk0 edge
- rd_set  in  S_INDEX  set to look up
- rd_valid  in  WAYS  valid bits of that set's ways, captured with rd_set
- rd_resp  out  1  lookup result valid, one cycle after accepted rd_en
- rd_victim  out  W_IDX  way to replace
- rd_state  out  WAYS-1  PLRU bits of the looked-up set
- upd_en  in  1  touch request (hit or fill)
- upd_set  in  S_INDEX  set to touch
- upd_way  in  W_IDX  way made most-recently-used
- flush_req  in  1  start clearing all sets
- busy  out  1  flush in progress; rd_en/upd_en ignored

## Operation
- State bits per set form a heap-indexed tree: node i has children 2i+1 and 2i+2; bit 0 is the root; leaves map to ways in order.
- Victim walk: at each node, bit=0 means descend to the lower-index half and bit=1 means the upper half. The leaf reached is the victim.
- Invalid preference: if captured rd_valid != all-ones, rd_victim is the lowest-index way whose valid bit is 0. The tree is ignored.
- Touch: for each node on upd_way's path, set the bit to point away from upd_way. The bit becomes 1 if upd_way is in the lower half, 0 otherwise. Nodes off the path are unchanged.
- FSM states:
  - IDLE:
    - Accepts rd_en/upd_en.
    - flush_req moves to FLUSH with counter=0.
  - FLUSH:
    - Each cycle, array[counter] <= 0 and counter increments.
    - After writing set NUM_SETS-1, returns to IDLE.
    - flush_req is ignored while in FLUSH.
- busy = (state == FLUSH).
- Requests are dropped, not queued, when busy is 1 or when flush_req is accepted in that same IDLE cycle.
- Update: on an accepted upd_en edge, array[upd_set] <= touch(array[upd_set], upd_way).
- Lookup:
  - On an accepted rd_en edge, rd_set and rd_valid are registered.
  - rd_victim and rd_state are combinational from array[rd_set_reg] in the following cycles.
  - Outputs hold their value until the next accepted rd_en, and track later writes to that set.
- Simultaneous rd_en and upd_en to the same set in the same cycle: the lookup result reflects the post-update state (write-first).

## Timing
- Reset (rst0_n low, asynchronous):
  - All array sets are 0, state = IDLE, counter = 0, busy = 0, rd_resp = 0.
  - rd_set_reg = 0 and rd_valid_reg = all-ones, so rd_victim = 0 and rd_state = 0.
- Lookup latency: rd_en accepted at edge N gives rd_resp high during cycle N+1 only.
- Update latency: visible to any lookup captured at the same edge or later.
- Flush duration:
  - flush_req accepted at edge N; busy is high from N+1 through the cycle before edge N+NUM_SETS.
  - busy is low after edge N+NUM_SETS.
- An rd_en in flight when flush_req is accepted completes normally: rd_resp pulses while busy is high and reflects the partially cleared state.
- Reset asserted mid-flush aborts the sweep immediately and clears everything.
- Counter wraps at NUM_SETS with no overflow state.

## Test plan
- Reset, WAYS=4, then rd_en set 3 with rd_valid=4'b1111 -> next cycle rd_resp=1, rd_victim=0, rd_state=3'b000.
- upd_en set 3 way 0, then lookup set 3 (all valid) -> rd_state=3'b011, rd_victim=2. Then touch way 2 and look up again -> rd_state=3'b110, rd_victim=1.
- Same-cycle upd_en (set 5, way 0) and rd_en (set 5, all valid) -> next cycle rd_state=3'b011, rd_victim=2 (write-first).
- Lookup set 3 (state 3'b110) with rd_valid=4'b1011 -> rd_victim=2 (invalid preferred over tree victim 1).
- Touch several sets, pulse flush_req, S_INDEX=4:
  - busy is high for exactly 16 cycles.
  - rd_en/upd_en during busy are dropped (no rd_resp, no array change).
  - After the flush, every set reads 3'b000.
- Deassert rst0_n asynchronously mid-flush -> busy=0 and rd_resp=0 immediately without a clock. After release, all sets read 0 and a new flush_req is accepted.
